// File: rtl/ysyx_dsq.sv
// Multi-lane in-order circular dispatch queue: LANES enqueue and LANES dequeue lanes per cycle.
// Latency: an entry is visible on out_valid/out_data exactly one cycle after it is enqueued, with no bypass.
// Backpressure: in_ready depends only on registered occupancy; pops never free space in the same cycle.
module ysyx_dsq #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int DW    = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*DW-1:0]        in_data,
  output logic                       in_ready,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*DW-1:0]        out_data,
  input  logic [LANES-1:0]           out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic [LANES-1:0] enq_mask;
  logic [LANES-1:0] pop_mask;
  logic [CW-1:0]    enq_k;
  logic [CW-1:0]    pop_k;
  logic             enq_run;
  logic             pop_run;

  // Space check uses registered occupancy only, so a full queue never admits on a pop cycle.
  assign in_ready = (CW'(DEPTH) - count_q) >= CW'(LANES);
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // Accepted lanes are the leading contiguous run from lane 0; the first gap ends the run.
  always_comb begin
    enq_mask = '0;
    pop_mask = '0;
    enq_k    = '0;
    pop_k    = '0;
    enq_run  = in_ready & ~flush;
    pop_run  = ~flush;
    for (int i = 0; i < LANES; i++) begin
      enq_run     = enq_run & in_valid[i];
      pop_run     = pop_run & (count_q > CW'(i)) & out_ready[i];
      enq_mask[i] = enq_run;
      pop_mask[i] = pop_run;
      enq_k       = enq_k + CW'(enq_run);
      pop_k       = pop_k + CW'(pop_run);
    end
  end

  // Next pointer/occupancy: flush wins over any enqueue or pop in the same cycle.
  always_comb begin
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_k);
      tail_d  = tail_q + AW'(enq_k);
      count_d = count_q + enq_k - pop_k;
    end
  end

  // Pointers and occupancy are the only reset state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; stale contents are masked by occupancy.
  always_ff @(posedge clock) begin
    for (int j = 0; j < LANES; j++) begin
      if (enq_mask[j]) begin
        mem_q[tail_q + AW'(j)] <= in_data[j*DW +: DW];
      end
    end
  end

  // Lane i presents the i-th oldest entry, zeroed when that entry does not exist.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      out_valid[i] = (count_q > CW'(i));
      if (count_q > CW'(i)) begin
        out_data[i*DW +: DW] = mem_q[head_q + AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_dsq.sv
// Bench for ysyx_dsq: directed corner cases followed by random traffic, checked against a queue model.
// Latency: model state is compared every cycle, away from the rising edge.
// Backpressure: model derives acceptance from its own occupancy.
module tb_ysyx_dsq;

  localparam int L  = 2;
  localparam int D  = 8;
  localparam int W  = 32;
  localparam int CW = $clog2(D) + 1;

  logic            clock;
  logic            reset;
  logic            flush;
  logic [L-1:0]    in_valid;
  logic [L*W-1:0]  in_data;
  logic            in_ready;
  logic [L-1:0]    out_valid;
  logic [L*W-1:0]  out_data;
  logic [L-1:0]    out_ready;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;

  int checks;
  int failures;

  logic [W-1:0] model_q[$];

  ysyx_dsq #(.LANES(L), .DEPTH(D), .DW(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output against the model's current contents.
  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    check({tag, ":count"}, 64'(count), 64'(n));
    check({tag, ":full"}, 64'(full), 64'(n == D));
    check({tag, ":empty"}, 64'(empty), 64'(n == 0));
    check({tag, ":in_ready"}, 64'(in_ready), 64'((D - n) >= L));
    for (int i = 0; i < L; i++) begin
      check($sformatf("%s:out_valid%0d", tag, i), 64'(out_valid[i]), 64'(n > i));
      check($sformatf("%s:out_data%0d", tag, i), 64'(out_data[i*W +: W]),
            (n > i) ? 64'(model_q[i]) : 64'd0);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model across the rising edge.
  task automatic cyc(input string tag, input logic fl, input logic [L-1:0] iv, input logic [L-1:0] ordy);
    int k;
    int p;
    bit room;
    logic [W-1:0] lane_dat [L];
    @(negedge clock);
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    for (int i = 0; i < L; i++) begin
      lane_dat[i] = $urandom;
      in_data[i*W +: W] = lane_dat[i];
    end
    #1;
    check_state(tag);
    room = (D - model_q.size()) >= L;
    k = 0;
    p = 0;
    if (room) begin
      for (int i = 0; i < L; i++) begin
        if (!iv[i]) break;
        k++;
      end
    end
    for (int i = 0; i < L; i++) begin
      if (!(i < model_q.size() && ordy[i])) break;
      p++;
    end
    @(posedge clock);
    if (fl) begin
      model_q.delete();
    end else begin
      for (int i = 0; i < p; i++) void'(model_q.pop_front());
      for (int i = 0; i < k; i++) model_q.push_back(lane_dat[i]);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    #1;
    check_state("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Two-lane enqueue appears together on the next cycle.
    cyc("enq2", 1'b0, 2'b11, 2'b00);
    cyc("after_enq2", 1'b0, 2'b10, 2'b00);   // gap at lane 0: nothing accepted
    cyc("gap", 1'b0, 2'b01, 2'b00);          // single entry behind the pair
    cyc("single", 1'b0, 2'b00, 2'b00);

    // Fill to 7: in_ready drops without full; then pop one to regain space.
    cyc("fill_a", 1'b0, 2'b11, 2'b00);
    cyc("fill_b", 1'b0, 2'b11, 2'b00);
    cyc("at7_drop", 1'b0, 2'b11, 2'b00);
    cyc("at7_pop", 1'b0, 2'b00, 2'b01);
    cyc("at6", 1'b0, 2'b01, 2'b00);
    cyc("at7_fullpop", 1'b0, 2'b11, 2'b11);  // pop does not free space this cycle
    cyc("at5", 1'b0, 2'b01, 2'b00);
    cyc("at6b", 1'b0, 2'b11, 2'b00);
    cyc("full8", 1'b0, 2'b11, 2'b00);

    // Count 3 with enqueue of 2 and out_ready=01, then out_ready=10.
    cyc("fl1", 1'b1, 2'b11, 2'b11);
    cyc("c2", 1'b0, 2'b11, 2'b00);
    cyc("c3", 1'b0, 2'b01, 2'b00);
    cyc("c3_pop01", 1'b0, 2'b11, 2'b01);
    cyc("c4", 1'b1, 2'b00, 2'b00);
    cyc("c0", 1'b0, 2'b11, 2'b00);
    cyc("c2b", 1'b0, 2'b01, 2'b00);
    cyc("c3_pop10", 1'b0, 2'b11, 2'b10);

    // Count 5 with flush and enqueue together.
    cyc("c5_flush", 1'b1, 2'b11, 2'b11);
    cyc("post_flush", 1'b0, 2'b00, 2'b00);

    // Streaming enqueue 2 / pop 2 wraps the pointers several times.
    cyc("prime", 1'b0, 2'b11, 2'b00);
    for (int n = 0; n < 20; n++) cyc("stream", 1'b0, 2'b11, 2'b11);

    // Asynchronous reset in the middle of traffic.
    cyc("pre_rst", 1'b0, 2'b11, 2'b00);
    @(negedge clock);
    in_valid  = 2'b11;
    out_ready = 2'b01;
    #2;
    reset = 1'b0;
    model_q.delete();
    #1;
    check_state("async_rst");
    @(posedge clock);
    #1;
    check_state("rst_edge");
    @(negedge clock);
    in_valid  = '0;
    out_ready = '0;
    reset     = 1'b1;
    cyc("post_rst", 1'b0, 2'b11, 2'b00);
    cyc("post_rst2", 1'b0, 2'b00, 2'b01);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cyc("rand", ($urandom_range(0, 31) == 0), L'($urandom), L'($urandom));
    end
    cyc("final", 1'b0, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
